// File: rtl/spiral_pkg.sv
// Shared types and constants for the spiral animation scheduler.
// The state encoding is fixed because it is exported on the debug state port.
package spiral_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEL  = 2'd1,
    CRUISE = 2'd2,
    DECEL  = 2'd3
  } anim_state_t;

  localparam logic [1:0] SPEED_MAX = 2'd3;

endpackage

// File: rtl/frame_edge_det.sv
// Detects the transition of vsync into its active level and emits a registered one-clk pulse.
// The history register resets to the active level, so a reset released mid-vsync does not fire.
module frame_edge_det #(
  parameter logic POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  output logic pulse_o
);

  logic vsync_q;
  logic pulse_q;
  logic edge_d;

  assign edge_d  = (vsync_i == POL) && (vsync_q != POL);
  assign pulse_o = pulse_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= POL;
      pulse_q <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      pulse_q <= edge_d;
    end
  end

endmodule

// File: rtl/spiral_anim_ctrl.sv
// Frame-synchronous animation scheduler: rotation offset, speed ramp with direction
// reversal only through zero speed, and frame-latched colour configuration.
module spiral_anim_ctrl
  import spiral_pkg::*;
#(
  parameter int   OFFS_W      = 5,
  parameter int   RAMP_FRAMES = 4,
  parameter logic VSYNC_POL   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic [1:0]        cfg_speed,
  input  logic              cfg_dir,
  input  logic              cfg_pause,
  input  logic [2:0]        cfg_fg,
  input  logic [2:0]        cfg_bg,
  output logic [OFFS_W-1:0] angle_offset,
  output logic [1:0]        cur_speed,
  output logic              cur_dir,
  output logic [2:0]        fg_q,
  output logic [2:0]        bg_q,
  output logic              frame_pulse,
  output logic [1:0]        state
);

  localparam int CNT_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

  logic [OFFS_W-1:0] offset_q, offset_d;
  logic [1:0]        speed_q, speed_d;
  logic              dir_q, dir_d;
  logic [2:0]        fg_d, bg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  anim_state_t       state_q, state_d;

  logic [OFFS_W-1:0] step;
  logic [1:0]        tgt;
  logic [1:0]        speed_dec;
  logic              ramp_tick;

  frame_edge_det #(
    .POL (VSYNC_POL)
  ) u_frame_edge_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync_i (vsync),
    .pulse_o (frame_pulse)
  );

  // A pending reversal forces the target to zero so the ramp drains before the flip.
  assign tgt       = (cfg_pause || (cfg_dir != dir_q)) ? 2'd0 : cfg_speed;
  assign step      = OFFS_W'(speed_q);
  assign speed_dec = speed_q - 2'd1;
  assign ramp_tick = (cnt_q == CNT_W'(RAMP_FRAMES - 1));

  always_comb begin
    // NOTE: every next-state value gets its hold value first, so no branch can infer a latch.
    offset_d = offset_q;
    speed_d  = speed_q;
    dir_d    = dir_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    cnt_d    = cnt_q;
    state_d  = state_q;

    if (frame_pulse) begin
      offset_d = dir_q ? (offset_q - step) : (offset_q + step);
      fg_d     = cfg_fg;
      bg_d     = cfg_bg;
      cnt_d    = ramp_tick ? '0 : (cnt_q + CNT_W'(1));

      if (ramp_tick) begin
        unique case (state_q)
          IDLE: begin
            dir_d = cfg_dir;
            if ((cfg_dir == dir_q) && (tgt != 2'd0)) begin
              speed_d = 2'd1;
              state_d = ACCEL;
            end
          end
          ACCEL: begin
            if ((speed_q < tgt) && (speed_q != SPEED_MAX)) speed_d = speed_q + 2'd1;
            else if (speed_q == tgt)                        state_d = CRUISE;
            else if (speed_q > tgt)                         state_d = DECEL;
          end
          CRUISE: begin
            if (tgt > speed_q)      state_d = ACCEL;
            else if (tgt < speed_q) state_d = DECEL;
          end
          DECEL: begin
            if (tgt > speed_q) begin
              state_d = ACCEL;
            end else if (speed_q > tgt) begin
              speed_d = speed_dec;
              if (speed_dec == 2'd0)     state_d = IDLE;
              else if (speed_dec == tgt) state_d = CRUISE;
            end else begin
              state_d = (speed_q == 2'd0) ? IDLE : CRUISE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q <= '0;
      speed_q  <= 2'd0;
      dir_q    <= 1'b0;
      fg_q     <= 3'd0;
      bg_q     <= 3'd0;
      cnt_q    <= '0;
      state_q  <= IDLE;
    end else begin
      offset_q <= offset_d;
      speed_q  <= speed_d;
      dir_q    <= dir_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  assign angle_offset = offset_q;
  assign cur_speed    = speed_q;
  assign cur_dir      = dir_q;
  assign state        = state_q;

endmodule
